// File: rtl/xlgmii_tx_frame_arbiter.sv
// Frame-atomic round-robin arbiter sharing one 128-bit AXI4-Stream TX path between
// NUM_SRC sources, with a 2-entry registered skid buffer and underrun detection.
module xlgmii_tx_frame_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [NUM_SRC*128-1:0]     s_tdata,
  input  logic [NUM_SRC*16-1:0]      s_tkeep,
  input  logic [NUM_SRC-1:0]         s_tvalid,
  input  logic [NUM_SRC-1:0]         s_tlast,
  output logic [NUM_SRC-1:0]         s_tready,
  output logic [127:0]               m_tdata,
  output logic [15:0]                m_tkeep,
  output logic                       m_tvalid,
  output logic                       m_tlast,
  input  logic                       m_tready,
  output logic [$clog2(NUM_SRC)-1:0] grant_idx,
  output logic                       busy,
  output logic                       underrun,
  output logic [CNT_WIDTH-1:0]       frame_cnt,
  output logic [CNT_WIDTH-1:0]       underrun_cnt
);

  localparam int GW = $clog2(NUM_SRC);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t               r_state;
  logic [GW-1:0]        r_grant;
  logic                 r_started;
  logic                 r_underrun;
  logic [CNT_WIDTH-1:0] r_frame_cnt;
  logic [CNT_WIDTH-1:0] r_underrun_cnt;

  logic                 r_out_vld;
  logic [127:0]         r_out_data;
  logic [15:0]          r_out_keep;
  logic                 r_out_last;
  logic                 r_skd_vld;
  logic [127:0]         r_skd_data;
  logic [15:0]          r_skd_keep;
  logic                 r_skd_last;

  logic                 w_full;
  logic                 w_ready_g;
  logic                 w_sel_valid;
  logic                 w_sel_last;
  logic [127:0]         w_sel_data;
  logic [15:0]          w_sel_keep;
  logic                 w_accept;
  logic                 w_pop;
  logic                 w_gap;

  // Scanning downward lets the nearest requester after prev overwrite the others.
  function automatic logic [GW-1:0] rr_pick(input logic [GW-1:0] prev,
                                            input logic [NUM_SRC-1:0] req);
    logic [GW-1:0] pick;
    int            idx;
    pick = prev;
    for (int i = NUM_SRC; i >= 1; i--) begin
      idx = (int'(prev) + i) % NUM_SRC;
      if (req[idx]) pick = GW'(idx);
    end
    return pick;
  endfunction

  assign w_full      = r_out_vld & r_skd_vld;
  assign w_ready_g   = (r_state == ST_LOCKED) & ~w_full;
  assign w_sel_valid = s_tvalid[r_grant];
  assign w_sel_last  = s_tlast[r_grant];
  assign w_sel_data  = s_tdata[r_grant*128 +: 128];
  assign w_sel_keep  = s_tkeep[r_grant*16 +: 16];
  assign w_accept    = w_ready_g & w_sel_valid;
  assign w_pop       = r_out_vld & m_tready;
  assign w_gap       = w_ready_g & ~w_sel_valid & r_started;

  always_comb begin
    s_tready = '0;
    if (w_ready_g) begin
      s_tready[r_grant] = 1'b1;
    end else begin
      s_tready = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_grant   <= GW'(NUM_SRC - 1);
      r_started <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable && (|s_tvalid)) begin
            r_grant   <= rr_pick(r_grant, s_tvalid);
            r_state   <= ST_LOCKED;
            r_started <= 1'b0;
          end
        end
        ST_LOCKED: begin
          if (w_accept) begin
            if (w_sel_last) begin
              r_state   <= ST_IDLE;
              r_started <= 1'b0;
            end else begin
              r_started <= 1'b1;
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_started <= 1'b0;
        end
      endcase
    end
  end

  // Output register is the head entry; the skid entry only fills while the bridge stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld  <= 1'b0;
      r_out_data <= 128'd0;
      r_out_keep <= 16'd0;
      r_out_last <= 1'b0;
      r_skd_vld  <= 1'b0;
      r_skd_data <= 128'd0;
      r_skd_keep <= 16'd0;
      r_skd_last <= 1'b0;
    end else begin
      if (!r_out_vld || w_pop) begin
        if (r_skd_vld) begin
          r_out_vld  <= 1'b1;
          r_out_data <= r_skd_data;
          r_out_keep <= r_skd_keep;
          r_out_last <= r_skd_last;
          r_skd_vld  <= 1'b0;
        end else begin
          r_out_vld <= w_accept;
          if (w_accept) begin
            r_out_data <= w_sel_data;
            r_out_keep <= w_sel_keep;
            r_out_last <= w_sel_last;
          end
        end
      end else if (w_accept) begin
        r_skd_vld  <= 1'b1;
        r_skd_data <= w_sel_data;
        r_skd_keep <= w_sel_keep;
        r_skd_last <= w_sel_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_underrun     <= 1'b0;
      r_frame_cnt    <= '0;
      r_underrun_cnt <= '0;
    end else begin
      r_underrun <= w_gap;
      if (w_pop && r_out_last && (r_frame_cnt != {CNT_WIDTH{1'b1}})) begin
        r_frame_cnt <= r_frame_cnt + CNT_WIDTH'(1);
      end
      if (w_gap && (r_underrun_cnt != {CNT_WIDTH{1'b1}})) begin
        r_underrun_cnt <= r_underrun_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign m_tdata      = r_out_data;
  assign m_tkeep      = r_out_keep;
  assign m_tvalid     = r_out_vld;
  assign m_tlast      = r_out_last;
  assign grant_idx    = r_grant;
  assign busy         = (r_state == ST_LOCKED);
  assign underrun     = r_underrun;
  assign frame_cnt    = r_frame_cnt;
  assign underrun_cnt = r_underrun_cnt;

endmodule

// File: tb/tb_xlgmii_tx_frame_arbiter.sv
// Directed bench for xlgmii_tx_frame_arbiter: per-source beat queues drive the inputs,
// a monitor records output handshakes, and each test task compares against hand-built frames.
module tb_xlgmii_tx_frame_arbiter;
  localparam int NUM_SRC   = 4;
  localparam int CNT_WIDTH = 16;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   enable = 1'b0;
  logic [NUM_SRC*128-1:0] s_tdata = '0;
  logic [NUM_SRC*16-1:0]  s_tkeep = '0;
  logic [NUM_SRC-1:0]     s_tvalid = '0;
  logic [NUM_SRC-1:0]     s_tlast = '0;
  logic [NUM_SRC-1:0]     s_tready;
  logic [127:0]           m_tdata;
  logic [15:0]            m_tkeep;
  logic                   m_tvalid;
  logic                   m_tlast;
  logic                   m_tready = 1'b1;
  logic [1:0]             grant_idx;
  logic                   busy;
  logic                   underrun;
  logic [CNT_WIDTH-1:0]   frame_cnt;
  logic [CNT_WIDTH-1:0]   underrun_cnt;

  xlgmii_tx_frame_arbiter #(.NUM_SRC(NUM_SRC), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready),
    .grant_idx(grant_idx), .busy(busy), .underrun(underrun),
    .frame_cnt(frame_cnt), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
    logic [7:0]   gap;
  } beat_t;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  beat_t        src_q[NUM_SRC][$];
  logic [144:0] out_q[$];
  logic [144:0] exp_q[$];
  int           acc_cyc[$];
  int           out_cyc[$];
  int           ur_pulses = 0;
  int           stalls = 0;
  int           stall_viol = 0;
  logic         prev_stall = 1'b0;
  logic [144:0] prev_m = '0;

  function automatic logic [127:0] mk_data(input int s, input int f, input int b);
    return {8'(s), 8'(f), 8'(b), {13{8'hA5}}};
  endfunction

  task automatic push_frame(input int s, input int f, input int n, input logic [15:0] lk,
                            input int gap_idx, input int gap_len);
    beat_t bt;
    for (int b = 0; b < n; b++) begin
      bt.data = mk_data(s, f, b);
      bt.keep = (b == n - 1) ? lk : 16'hFFFF;
      bt.last = (b == n - 1);
      bt.gap  = (b == gap_idx) ? 8'(gap_len) : 8'd0;
      src_q[s].push_back(bt);
    end
  endtask

  task automatic add_exp(input int s, input int f, input int n, input logic [15:0] lk);
    for (int b = 0; b < n; b++) begin
      exp_q.push_back({mk_data(s, f, b), (b == n - 1) ? lk : 16'hFFFF, (b == n - 1) ? 1'b1 : 1'b0});
    end
  endtask

  task automatic drive();
    beat_t bt;
    for (int s = 0; s < NUM_SRC; s++) begin
      s_tvalid[s]          = 1'b0;
      s_tlast[s]           = 1'b0;
      s_tdata[s*128 +: 128] = '0;
      s_tkeep[s*16 +: 16]   = '0;
      if (src_q[s].size() > 0) begin
        bt = src_q[s][0];
        if (bt.gap != 8'd0) begin
          bt.gap = bt.gap - 8'd1;
          src_q[s][0] = bt;
        end else begin
          s_tvalid[s]           = 1'b1;
          s_tlast[s]            = bt.last;
          s_tdata[s*128 +: 128] = bt.data;
          s_tkeep[s*16 +: 16]   = bt.keep;
        end
      end
    end
  endtask

  // Samples handshakes just before the edge, then advances one cycle and re-drives sources.
  task automatic tick();
    #2;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (s_tvalid[s] && s_tready[s]) begin
        void'(src_q[s].pop_front());
        acc_cyc.push_back(cyc);
      end
    end
    if (prev_stall && ({m_tdata, m_tkeep, m_tlast} !== prev_m)) stall_viol++;
    prev_stall = m_tvalid && !m_tready;
    prev_m     = {m_tdata, m_tkeep, m_tlast};
    if (prev_stall) stalls++;
    if (m_tvalid && m_tready) begin
      out_q.push_back({m_tdata, m_tkeep, m_tlast});
      out_cyc.push_back(cyc);
    end
    if (underrun) ur_pulses++;
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  task automatic run_until_out(input int n, input int budget);
    for (int c = 0; c < budget && out_q.size() < n; c++) tick();
  endtask

  task automatic clear_mon();
    out_q.delete(); exp_q.delete(); acc_cyc.delete(); out_cyc.delete();
    ur_pulses = 0; stalls = 0; stall_viol = 0;
  endtask

  task automatic apply_reset();
    for (int s = 0; s < NUM_SRC; s++) src_q[s].delete();
    clear_mon();
    prev_stall = 1'b0;
    rst_n = 1'b0;
    drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    checks++; if (s_tready !== 4'b0000) begin errors++; $display("FAIL rst_s_tready got %0h exp %0h", s_tready, 4'b0000); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_tvalid got %0h exp %0h", m_tvalid, 1'b0); end
    checks++; if ({m_tdata, m_tkeep, m_tlast} !== 145'd0) begin errors++; $display("FAIL rst_m_data got %0h exp 0", {m_tdata, m_tkeep, m_tlast}); end
    checks++; if (grant_idx !== 2'd3) begin errors++; $display("FAIL rst_grant got %0d exp %0d", grant_idx, 3); end
    checks++; if ({busy, underrun} !== 2'b00) begin errors++; $display("FAIL rst_busy_underrun got %0b exp %0b", {busy, underrun}, 2'b00); end
    checks++; if ({frame_cnt, underrun_cnt} !== 32'd0) begin errors++; $display("FAIL rst_counters got %0h exp 0", {frame_cnt, underrun_cnt}); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    clear_mon();
    enable = 1'b1;
    m_tready = 1'b1;
    push_frame(0, 1, 3, 16'h00FF, -1, 0);
    add_exp(0, 1, 3, 16'h00FF);
    drive();
    #1;
    checks++; if ({busy, s_tready} !== 5'b0_0000) begin errors++; $display("FAIL t1_idle_bubble got %0b exp %0b", {busy, s_tready}, 5'b0_0000); end
    tick();
    checks++; if ({busy, grant_idx, s_tready} !== 7'b1_00_0001) begin errors++; $display("FAIL t1_locked got %0b exp %0b", {busy, grant_idx, s_tready}, 7'b1_00_0001); end
    run_until_out(3, 20);
    checks++; if (out_q.size() != 3) begin errors++; $display("FAIL t1_beat_count got %0d exp %0d", out_q.size(), 3); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++; if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL t1_beat%0d got %0h exp %0h", i, out_q[i], exp_q[i]); end
    end
    if (out_cyc.size() == 3 && acc_cyc.size() == 3) begin
      checks++; if (out_cyc[2] - out_cyc[0] != 2) begin errors++; $display("FAIL t1_contiguous got %0d exp %0d", out_cyc[2] - out_cyc[0], 2); end
      checks++; if (out_cyc[0] - acc_cyc[0] != 1) begin errors++; $display("FAIL t1_latency got %0d exp %0d", out_cyc[0] - acc_cyc[0], 1); end
    end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL t1_frame_cnt got %0d exp %0d", frame_cnt, 1); end
    checks++; if ({busy, grant_idx} !== 3'b0_00) begin errors++; $display("FAIL t1_end_state got %0b exp %0b", {busy, grant_idx}, 3'b0_00); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    enable = 1'b1;
    push_frame(0, 2, 2, 16'hFFFF, -1, 0);
    push_frame(0, 3, 2, 16'h0FFF, -1, 0);
    for (int s = 1; s < NUM_SRC; s++) push_frame(s, 2, 2, 16'h00F0, -1, 0);
    add_exp(0, 2, 2, 16'hFFFF);
    for (int s = 1; s < NUM_SRC; s++) add_exp(s, 2, 2, 16'h00F0);
    add_exp(0, 3, 2, 16'h0FFF);
    drive();
    run_until_out(10, 80);
    checks++; if (out_q.size() != 10) begin errors++; $display("FAIL t2_beat_count got %0d exp %0d", out_q.size(), 10); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++; if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL t2_beat%0d got %0h exp %0h", i, out_q[i], exp_q[i]); end
    end
    checks++; if (frame_cnt !== 16'd5) begin errors++; $display("FAIL t2_frame_cnt got %0d exp %0d", frame_cnt, 5); end
  endtask

  task automatic test_underrun();
    clear_mon();
    push_frame(2, 7, 3, 16'hFFFF, 1, 2);
    add_exp(2, 7, 3, 16'hFFFF);
    drive();
    run_until_out(3, 30);
    checks++; if (ur_pulses != 2) begin errors++; $display("FAIL t3_underrun_pulses got %0d exp %0d", ur_pulses, 2); end
    checks++; if (underrun_cnt !== 16'd2) begin errors++; $display("FAIL t3_underrun_cnt got %0d exp %0d", underrun_cnt, 2); end
    checks++; if (out_q.size() != 3) begin errors++; $display("FAIL t3_beat_count got %0d exp %0d", out_q.size(), 3); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++; if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL t3_beat%0d got %0h exp %0h", i, out_q[i], exp_q[i]); end
    end
    checks++; if ({grant_idx, frame_cnt} !== {2'd2, 16'd6}) begin errors++; $display("FAIL t3_grant_frames got %0h exp %0h", {grant_idx, frame_cnt}, {2'd2, 16'd6}); end
  endtask

  task automatic test_backpressure();
    logic [3:0] pat;
    int         k;
    clear_mon();
    pat = 4'b1001;
    k   = 0;
    push_frame(3, 4, 4, 16'h7FFF, -1, 0);
    add_exp(3, 4, 4, 16'h7FFF);
    drive();
    for (int c = 0; c < 40 && out_q.size() < 4; c++) begin
      if (m_tvalid && k < 4) begin
        m_tready = pat[k];
        k++;
      end else begin
        m_tready = 1'b1;
      end
      tick();
    end
    m_tready = 1'b1;
    checks++; if (stalls != 2) begin errors++; $display("FAIL t4_stall_cycles got %0d exp %0d", stalls, 2); end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL t4_stable_while_stalled got %0d exp %0d", stall_viol, 0); end
    checks++; if (out_q.size() != 4) begin errors++; $display("FAIL t4_beat_count got %0d exp %0d", out_q.size(), 4); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++; if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL t4_beat%0d got %0h exp %0h", i, out_q[i], exp_q[i]); end
    end
    checks++; if (frame_cnt !== 16'd7) begin errors++; $display("FAIL t4_frame_cnt got %0d exp %0d", frame_cnt, 7); end
  endtask

  task automatic test_enable_hold();
    clear_mon();
    push_frame(0, 9, 4, 16'hFFFF, -1, 0);
    push_frame(1, 9, 2, 16'h0000, -1, 0);
    add_exp(0, 9, 4, 16'hFFFF);
    drive();
    for (int c = 0; c < 40 && out_q.size() < 4; c++) begin
      if (src_q[0].size() <= 3) enable = 1'b0;
      tick();
    end
    for (int c = 0; c < 5; c++) tick();
    checks++; if ({busy, s_tready} !== 5'b0_0000) begin errors++; $display("FAIL t5_held_idle got %0b exp %0b", {busy, s_tready}, 5'b0_0000); end
    checks++; if (src_q[1].size() != 2) begin errors++; $display("FAIL t5_src1_waiting got %0d exp %0d", src_q[1].size(), 2); end
    checks++; if (out_q.size() != 4) begin errors++; $display("FAIL t5_beat_count got %0d exp %0d", out_q.size(), 4); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++; if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL t5_beat%0d got %0h exp %0h", i, out_q[i], exp_q[i]); end
    end
    checks++; if (frame_cnt !== 16'd8) begin errors++; $display("FAIL t5_frame_cnt got %0d exp %0d", frame_cnt, 8); end
    enable = 1'b1;
    tick();
    checks++; if ({busy, grant_idx} !== 3'b1_01) begin errors++; $display("FAIL t5_regrant got %0b exp %0b", {busy, grant_idx}, 3'b1_01); end
    add_exp(1, 9, 2, 16'h0000);
    run_until_out(6, 20);
    checks++; if (out_q.size() != 6) begin errors++; $display("FAIL t5_total_beats got %0d exp %0d", out_q.size(), 6); end
    for (int i = 4; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++; if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL t5_keep0_beat%0d got %0h exp %0h", i, out_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    push_frame(0, 11, 4, 16'hFFFF, -1, 0);
    drive();
    run_until_out(1, 20);
    rst_n = 1'b0;
    #1;
    checks++; if ({m_tvalid, s_tready, busy, underrun} !== 7'd0) begin errors++; $display("FAIL t6_outputs_cleared got %0b exp 0", {m_tvalid, s_tready, busy, underrun}); end
    checks++; if ({frame_cnt, underrun_cnt} !== 32'd0) begin errors++; $display("FAIL t6_counters_cleared got %0h exp 0", {frame_cnt, underrun_cnt}); end
    checks++; if (grant_idx !== 2'd3) begin errors++; $display("FAIL t6_grant_reset got %0d exp %0d", grant_idx, 3); end
    apply_reset();
    push_frame(2, 12, 2, 16'hFFFF, -1, 0);
    push_frame(0, 12, 2, 16'hFFFF, -1, 0);
    drive();
    tick();
    checks++; if ({busy, grant_idx} !== 3'b1_00) begin errors++; $display("FAIL t6_first_grant got %0b exp %0b", {busy, grant_idx}, 3'b1_00); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_underrun();
    test_backpressure();
    test_enable_hold();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
